// File: rtl/apb3_requester_core.sv
// APB3 requester: turns a single-outstanding valid/ready command into SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is compiled in with APB3_REQUESTER_TIMEOUT_EN.
module apb3_requester_core #(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [AddressWidth-1:0] i_req_addr,
    input  logic [DataWidth-1:0]    i_req_wdata,
    output logic                    o_rsp_valid,
    output logic [DataWidth-1:0]    o_rsp_rdata,
    output logic                    o_rsp_error,
    output logic [AddressWidth-1:0] o_paddr,
    output logic                    o_pselx,
    output logic                    o_penable,
    output logic                    o_pwrite,
    output logic [DataWidth-1:0]    o_pwdata,
    input  logic                    i_pready,
    input  logic [DataWidth-1:0]    i_prdata,
    input  logic                    i_pslverr
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                  r_state;
    logic                    r_pselx, r_penable, r_pwrite;
    logic [AddressWidth-1:0] r_paddr;
    logic [DataWidth-1:0]    r_pwdata;
    logic                    r_rsp_valid, r_rsp_error;
    logic [DataWidth-1:0]    r_rsp_rdata;

    // Byte offset within a data word is never driven onto the bus.
    logic [AddressWidth-1:0] w_addr_mask;
    assign w_addr_mask = ~(AddressWidth'(DataWidth/8 - 1));

`ifdef APB3_REQUESTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TimeoutCycles + 1);
    logic [TO_W-1:0] r_wait_cnt;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TimeoutCycles;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB3_REQUESTER_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_paddr  <= i_req_addr & w_addr_mask;
                        r_pwrite <= i_req_write;
                        r_pwdata <= i_req_write ? i_req_wdata : '0;
                        r_pselx  <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB3_REQUESTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (i_pready) begin
                        r_pselx     <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= i_pslverr;
                        r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
                        r_state     <= S_IDLE;
                    end else begin
`ifdef APB3_REQUESTER_TIMEOUT_EN
                        // Abort on the edge that ends the TimeoutCycles-th wait cycle.
                        if (r_wait_cnt == TO_W'(TimeoutCycles - 1)) begin
                            r_pselx     <= 1'b0;
                            r_penable   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_pselx     = r_pselx;
    assign o_penable   = r_penable;
    assign o_pwrite    = r_pwrite;
    assign o_paddr     = r_paddr;
    assign o_pwdata    = r_pwdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_error = r_rsp_error;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb3_requester_core.sv
// Directed bench for apb3_requester_core: cycle-exact bus checks plus a response scoreboard.
module tb_apb3_requester_core;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk, rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr, paddr;
    logic [DW-1:0] req_wdata, rsp_rdata, pwdata, prdata;
    logic          rsp_valid, rsp_error, pselx, penable, pwrite, pready, pslverr;

    int tests, failed;
    logic [DW:0] exp_q[$];   // {error, rdata}

    apb3_requester_core #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
        .o_paddr(paddr), .o_pselx(pselx), .o_penable(penable), .o_pwrite(pwrite),
        .o_pwdata(pwdata), .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("sb_rsp", {31'd0, rsp_error, rsp_rdata}, {31'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        pready = 1'b1; prdata = '0; pslverr = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_bus", {pselx, penable, pwrite, rsp_valid, rsp_error}, 0);
        chk("rst_data", {paddr, pwdata}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Write, zero-wait completer
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0004; req_wdata = 32'hDEAD_BEEF;
        chk("w_ready_idle", req_ready, 1);
        tick();
        exp_q.push_back({1'b0, 32'h0});
        req_valid = 1'b0;
        chk("w_setup", {pselx, penable, pwrite, req_ready}, 4'b1010);
        chk("w_paddr", paddr, 32'h1000_0004);
        chk("w_pwdata", pwdata, 32'hDEAD_BEEF);
        tick();
        chk("w_access", {pselx, penable, req_ready, rsp_valid}, 4'b1100);
        tick();
        chk("w_done", {pselx, penable, req_ready, rsp_valid, rsp_error}, 5'b00110);
        chk("w_rdata", rsp_rdata, 0);

        // Read with 3 wait states; pslverr/prdata noise during waits is ignored
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
        tick();
        exp_q.push_back({1'b0, 32'h1234_5678});
        req_valid = 1'b0; pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        chk("r_setup", {pselx, penable, pwrite}, 3'b100);
        chk("r_pwdata", pwdata, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_access", {pselx, penable, rsp_valid, req_ready}, 4'b1100);
            chk("r_paddr", paddr, 32'h20);
        end
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
        tick();
        chk("r_done", {pselx, penable, rsp_valid}, 3'b001);
        chk("r_rdata", rsp_rdata, 32'h1234_5678);
        prdata = 32'h5555_5555;
        tick();
        chk("r_hold", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b0, 32'h1234_5678});

        // Unaligned read with slave error
        req_valid = 1'b1; req_addr = 32'h23; prdata = 32'hCAFE_F00D; pslverr = 1'b1;
        tick();
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        req_valid = 1'b0;
        chk("e_paddr", paddr, 32'h20);
        tick(); tick();
        chk("e_done", {rsp_valid, rsp_error}, 2'b11);
        chk("e_rdata", rsp_rdata, 32'hCAFE_F00D);
        pslverr = 1'b0;
        tick();

        // Three back-to-back writes with req_valid held high
        req_valid = 1'b1; req_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'h100 + 32'(k * 4); req_wdata = 32'hA000_0000 + 32'(k);
            chk("b_ready", req_ready, 1);
            tick();
            exp_q.push_back({1'b0, 32'h0});
            chk("b_setup", {pselx, penable, req_ready}, 3'b100);
            chk("b_addr", {paddr, pwdata}, {32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k)});
            tick();
            chk("b_access", {pselx, penable, req_ready}, 3'b110);
            tick();
            chk("b_gap", {pselx, penable, rsp_valid, req_ready}, 4'b0011);
        end
        req_valid = 1'b0;
        tick();

        // pready stuck low
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; prdata = 32'h7777_7777; pready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
`ifdef APB3_REQUESTER_TIMEOUT_EN
        exp_q.push_back({1'b1, 32'h0});
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("t_waiting", {pselx, penable, rsp_valid}, 3'b110);
        end
        tick();
        chk("t_abort", {pselx, penable, rsp_valid, rsp_error, req_ready}, 5'b00111);
        chk("t_rdata", rsp_rdata, 0);
        tick();
        req_valid = 1'b1; req_addr = 32'h44;
        tick();
        req_valid = 1'b0;
        tick(); tick();
`else
        for (int i = 0; i < 120; i++) begin
            tick();
            chk("s_stuck", {pselx, penable, rsp_valid, req_ready}, 4'b1100);
        end
`endif

        // Asynchronous reset mid-ACCESS
        chk("x_pre", {pselx, penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("x_async", {pselx, penable, rsp_valid, req_ready}, 4'b0001);
        chk("x_addr", paddr, 0);
        tick();
        rst_n = 1'b1; pready = 1'b1;
        tick();
        chk("x_norsp", rsp_valid, 0);

        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0808; req_wdata = 32'h0BAD_F00D;
        tick();
        exp_q.push_back({1'b0, 32'h0});
        req_valid = 1'b0;
        chk("n_setup", {pselx, penable, paddr, pwdata}, {2'b10, 32'h808, 32'h0BAD_F00D});
        tick(); tick();
        chk("n_done", {pselx, rsp_valid, rsp_error, req_ready}, 4'b0101);
        tick(); tick();

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apb3_requester_core.md
# apb3_requester_core

Synthesizable APB3 requester (manager) converting a single-outstanding valid/ready command stream into APB3 SETUP/ACCESS transfers, returning read data and error status on a one-cycle response strobe. Initiator-side counterpart of the Renode APB3 completer: placed between a Renode-driven command source (or CPU-side logic) and any APB3 completer under test in the Verilator/RTL co-simulation environment.

## Interface
- AddressWidth, 32, width of req_addr/paddr
- DataWidth, 32, width of data buses; 8, 16 or 32 only
- TimeoutCycles, 16, ACCESS-phase cycles without pready before abort (used only with timeout compiled in); minimum 1

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when high with req_valid
- req_write  input  1  1 = write, 0 = read
- req_addr  input  AddressWidth  byte address
- req_wdata  input  DataWidth  write data
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  DataWidth  read data (0 for writes/aborts)
- rsp_error  output  1  pslverr captured, or timeout
- paddr  output  AddressWidth  APB address
- pselx  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- pwdata  output  DataWidth  APB write data
- pready  input  1  completer ready
- prdata  input  DataWidth  completer read data
- pslverr  input  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- req_ready = (state == IDLE), combinational; 1 during and after reset.
- IDLE: on req_valid at clk edge -> capture write/addr/wdata into registers, go SETUP. Otherwise stay.
- SETUP: pselx=1, penable=0; unconditionally -> ACCESS next edge.
- ACCESS: pselx=1, penable=1; on edge with pready=1 -> IDLE, register rsp_valid=1, rsp_error=pslverr, rsp_rdata=prdata if read else 0. pready=0 -> stay (wait states, unbounded unless timeout enabled).
- paddr = captured address with low log2(DataWidth/8) bits forced to 0; paddr, pwrite, pwdata stable from SETUP through last ACCESS cycle.
- pwdata = captured wdata on writes, 0 on reads.
- In IDLE: pselx=0, penable=0; paddr/pwrite/pwdata hold last value (not required to be 0 after first transfer).
- prdata and pslverr ignored except on the completing ACCESS edge; pslverr ignored for nothing else.
- rsp_valid is a strobe; no back-pressure on response side. rsp_rdata/rsp_error hold until next response.
- Reset outputs: pselx, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_error all 0.
- Reset asserted mid-transfer: bus outputs drop to 0 immediately (async), no response emitted, command lost.

## Timing
- Command accepted at edge N -> SETUP in cycle N..N+1 -> ACCESS from N+1.
- Zero-wait completer: completion edge N+2, rsp_valid high in cycle N+2..N+3, req_ready high again same cycle.
- Each wait state (pready=0 in ACCESS) adds exactly one cycle.
- Max throughput: one transfer per 3 cycles (IDLE gap mandatory between transfers; pselx low for ≥1 cycle).
- req_valid in SETUP/ACCESS ignored (req_ready=0); requester holds command until accepted.

## Configuration
- APB3_REQUESTER_TIMEOUT_EN defined: counter cleared on entry to ACCESS, increments per ACCESS cycle with pready=0; when TimeoutCycles consecutive waits elapse -> IDLE, rsp_valid=1, rsp_error=1, rsp_rdata=0; pselx/penable drop next cycle. pready=1 on the same edge as expiry wins (normal completion).
- Not defined: no counter, ACCESS waits indefinitely; TimeoutCycles unused.

## Test plan
- Write 0x1000_0004 / 0xDEAD_BEEF, pready=1 always -> pselx=1 for 2 cycles, penable only 2nd, pwrite=1, pwdata=0xDEADBEEF; rsp_valid at N+2, rsp_error=0, rsp_rdata=0.
- Read 0x20, completer returns prdata=0x1234_5678 after 3 wait states -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678 at N+5, paddr stable throughout.
- Read 0x23 with pslverr=1 at completion -> paddr=0x20, rsp_error=1, rsp_rdata=prdata value.
- req_valid held high for 3 commands back-to-back -> each accepted 3 cycles apart, pselx low 1 cycle between transfers, req_ready low during SETUP/ACCESS.
- TIMEOUT_EN, TimeoutCycles=4, pready stuck 0 -> rsp_valid with rsp_error=1 after 4 ACCESS cycles, bus idle next cycle; without macro, ACCESS persists 100+ cycles.
- rst_n pulsed low during ACCESS -> pselx/penable 0 immediately, no rsp_valid, req_ready=1, next command runs normally.
